// File: rtl/clock_strobe_pkg.sv
// rtl/clock_strobe_pkg.sv - shared constants and helpers for the clock strobe generator
// Purpose: default counter width and reset divisor, the disabled-divisor code,
//          and the channel-select width function.
// Ports:   none (package).
package clock_strobe_pkg;

  localparam int CNT_W_DEFAULT    = 8;
  localparam int DIV_INIT_DEFAULT = 4;
  localparam int DIV_DISABLED     = 0;

  // Channel select needs at least one bit even for a single channel.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clock_strobe_channel.sv
// rtl/clock_strobe_channel.sv - one clock-enable channel with glitch-free divisor reload
// Purpose: counts 0..div-1, emits a tick on the last count and a divided clock that is
//          high for the first floor(div/2) counts. A reload request is held pending and
//          applied only at the period boundary, on align, or immediately when disabled.
// Ports:   clock, reset   master clock, synchronous active-high reset
//          align          restart the counter at 0 and apply any pending reload
//          cfg_sel        request addressed to this channel (cfg_valid already folded in)
//          cfg_div        requested divisor
//          pend           reload pending (doubles as the channel's not-ready flag)
//          tick, div_clk, active   registered channel outputs
module clock_strobe_channel
  import clock_strobe_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int DIV_INIT = DIV_INIT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             align,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             pend,
  output logic             tick,
  output logic             div_clk,
  output logic             active
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_INIT);
  localparam logic [CNT_W-1:0] DIV_OFF = CNT_W'(DIV_DISABLED);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt, div, pend_div;
  logic [CNT_W-1:0] cnt_next, div_next;
  logic             enabled, at_wrap, apply, xfer;

  always_comb begin
    xfer     = cfg_sel && !pend;
    enabled  = (div != DIV_OFF);
    at_wrap  = enabled && (cnt == div - ONE);
    // pend is a flop, so a request accepted this cycle cannot be applied until a later edge.
    apply    = pend && (align || !enabled || at_wrap);
    cnt_next = cnt;
    div_next = div;
    if (apply) begin
      div_next = pend_div;
      cnt_next = '0;
    end else if (!enabled || align || at_wrap) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      div      <= DIV_RST;
      pend     <= 1'b0;
      pend_div <= '0;
      tick     <= 1'b0;
      div_clk  <= 1'b0;
      active   <= (DIV_RST != DIV_OFF);
    end else begin
      cnt <= cnt_next;
      div <= div_next;
      if (apply) pend <= 1'b0;
      if (xfer) begin
        pend     <= 1'b1;
        pend_div <= cfg_div;
      end
      // Outputs are registered from the next state so they line up with cnt.
      tick    <= (div_next != DIV_OFF) && (cnt_next == div_next - ONE);
      div_clk <= (cnt_next < (div_next >> 1));
      active  <= (div_next != DIV_OFF);
    end
  end

endmodule

// File: rtl/clock_strobe_gen.sv
// rtl/clock_strobe_gen.sv - multi-channel clock-enable generator
// Purpose: NUM_CH independently reprogrammable strobe/divided-clock channels sharing a
//          single reload port and a common re-phase (align) pulse.
// Ports:   clock, reset      master clock, synchronous active-high reset
//          align             restart all enabled channels at count 0
//          cfg_valid/cfg_ch/cfg_div/cfg_ready   reload handshake (cfg_ch >= NUM_CH is dropped)
//          tick, div_clk, active                per-channel registered outputs
module clock_strobe_gen
  import clock_strobe_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int DIV_INIT = DIV_INIT_DEFAULT,
  parameter int CH_W     = ch_w(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              align,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] active
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] sel;

  // Out-of-range channel numbers match nothing: ready stays 1 and the request is dropped.
  always_comb begin
    sel       = '0;
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        sel[i]    = cfg_valid;
        cfg_ready = !pend[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_strobe_channel #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_INIT)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .align   (align),
      .cfg_sel (sel[g]),
      .cfg_div (cfg_div),
      .pend    (pend[g]),
      .tick    (tick[g]),
      .div_clk (div_clk[g]),
      .active  (active[g])
    );
  end

endmodule
